// File: rtl/output_map_reader.sv
`default_nettype none
// ============================================================================
// Module   : output_map_reader
// Purpose  : Reads back KERNEL_COUNT convolution output maps of WORD_COUNT
//            words each, stored contiguously from base_addr, using a
//            synchronous single-port memory. Each word is presented on a
//            valid/ready stream and tagged with its kernel index and with
//            end-of-map / end-of-frame markers.
// Ports    : clk, rst (sync, active-low)
//            start, base_addr          - run request, base address
//            mem_rd_en, mem_addr,
//            mem_rdata                 - memory read port (1-cycle latency)
//            out_data, out_valid,
//            out_ready, out_kernel,
//            out_last_map, out_last    - tagged output stream
//            busy, done                - status
// Revision : 1.0 - initial release
// ============================================================================
module output_map_reader #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int WORD_COUNT   = 43,
  parameter int KERNEL_COUNT = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  output logic                            mem_rd_en,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(KERNEL_COUNT)-1:0] out_kernel,
  output logic                            out_last_map,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done
);

  // A single-word map still needs a 1-bit counter.
  localparam int c_word_w   = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam int c_kernel_w = $clog2(KERNEL_COUNT);
  localparam logic [c_word_w-1:0]   c_last_word   = c_word_w'(WORD_COUNT - 1);
  localparam logic [c_kernel_w-1:0] c_last_kernel = c_kernel_w'(KERNEL_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_PRESENT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [c_word_w-1:0]     r_word;
  logic [c_kernel_w-1:0]   r_kernel;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [c_kernel_w-1:0]   r_tag_kernel;
  logic                    r_tag_last_map;
  logic                    r_tag_last;
  logic                    w_word_last;
  logic                    w_kernel_last;
  logic                    w_handshake;

  assign w_word_last   = (r_word == c_last_word);
  assign w_kernel_last = (r_kernel == c_last_kernel);
  assign w_handshake   = (r_state == S_PRESENT) && out_ready;

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_word         <= '0;
      r_kernel       <= '0;
      r_data         <= '0;
      r_tag_kernel   <= '0;
      r_tag_last_map <= 1'b0;
      r_tag_last     <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr   <= base_addr;
            r_word   <= '0;
            r_kernel <= '0;
          end
        end
        S_WAIT: begin
          // Read data and tags are captured together so they stay
          // coherent for the whole time the word is presented.
          r_data         <= mem_rdata;
          r_tag_kernel   <= r_kernel;
          r_tag_last_map <= w_word_last;
          r_tag_last     <= w_word_last & w_kernel_last;
        end
        S_PRESENT: begin
          if (w_handshake) begin
            r_addr <= r_addr + 1'b1;
            if (w_word_last) begin
              r_word   <= '0;
              r_kernel <= r_kernel + 1'b1;
            end else begin
              r_word <= r_word + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and output decode
  always_comb begin
    w_next       = r_state;
    mem_rd_en    = 1'b0;
    mem_addr     = '0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_kernel   = '0;
    out_last_map = 1'b0;
    out_last     = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_ARM;
      end
      S_ARM: begin
        // Wait for the controller to release start before reading.
        if (!start) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        mem_rd_en = 1'b1;
        mem_addr  = r_addr;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        w_next = S_PRESENT;
      end
      S_PRESENT: begin
        out_valid    = 1'b1;
        out_data     = r_data;
        out_kernel   = r_tag_kernel;
        out_last_map = r_tag_last_map;
        out_last     = r_tag_last;
        if (w_handshake) w_next = r_tag_last ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/output_map_reader.md
Name: output_map_reader

Overview:
- Read-back engine for the convolution output feature maps that the CNN controller writes into data memory.
- After a start pulse, reads KERNEL_COUNT maps of WORD_COUNT words each, stored contiguously from a base address.
- Issues synchronous single-port memory reads and presents each word on a valid/ready output stream.
- Tags every word with its kernel index and end-of-map / end-of-frame markers.

Parameters:
- DATA_WIDTH, 8, width of one memory word and of out_data.
- ADDR_WIDTH, 8, memory address width.
- WORD_COUNT, 43, output words per kernel map. Must be ≥ 1.
- KERNEL_COUNT, 2, number of kernel maps. Must be ≥ 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request to begin read-back, level-sampled.
- base_addr  in  ADDR_WIDTH  address of word 0 of kernel 0. Latched when start is accepted.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_WIDTH  memory read address.
- mem_rdata  in  DATA_WIDTH  read data. Valid the cycle after mem_rd_en.
- out_data  out  DATA_WIDTH  stream word.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accepts the word.
- out_kernel  out  $clog2(KERNEL_COUNT)  kernel index of out_data.
- out_last_map  out  1  out_data is the last word of its kernel map.
- out_last  out  1  out_data is the last word of the final map.
- busy  out  1  high in every state except Idle.
- done  out  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset: rst==0 at a clk edge forces state Idle. Address, word and kernel counters clear to 0. All outputs are 0 from that edge.
- Reset is honoured in any state, mid-transfer included. Any word not yet accepted is discarded, with no done pulse.
- States: Idle, Arm, Issue, Wait, Present, Done.
- Idle:
  - All outputs 0.
  - If start==1: latch base_addr into the address register, clear word_idx and kernel_idx, go to Arm.
- Arm: stay while start==1. When start==0, go to Issue. This start/release handshake matches the controller's convention.
- Issue:
  - mem_rd_en=1 and mem_addr = address register, for exactly one cycle.
  - Go to Wait.
- Wait:
  - mem_rdata is captured into the out_data register at the end of this cycle.
  - out_kernel, out_last_map and out_last are registered from the counters at the same edge.
  - Go to Present.
- Present:
  - out_valid=1.
  - out_data and all tags are held stable until the handshake (out_valid & out_ready) completes.
  - On handshake, address register += 1, wrapping modulo 2^ADDR_WIDTH.
  - If word_idx == WORD_COUNT-1: word_idx←0 and kernel_idx+=1. Otherwise word_idx+=1.
  - If out_last==1, go to Done. Otherwise go to Issue.
  - Without handshake, stay in Present.
- Done: done=1 and out_valid=0 for one cycle, then go to Idle.
- Tags:
  - out_last_map = (word_idx==WORD_COUNT-1).
  - out_last = out_last_map & (kernel_idx==KERNEL_COUNT-1).
- Throughput: the minimum is one word per 3 cycles (Issue, Wait, Present with out_ready held high). First mem_rd_en is asserted 1 cycle after start falls.
- Concurrency rules:
  - start is ignored outside Idle.
  - out_ready is ignored outside Present.
  - mem_rdata is ignored outside Wait.
  - mem_rd_en never asserts outside Issue.
- Total reads per run: exactly WORD_COUNT*KERNEL_COUNT. Every address is read exactly once, in increasing order.
- base_addr changes after the Idle latch edge have no effect on the current run.

Test Plan:
- Basic run:
  - Stimulus: WORD_COUNT=43, KERNEL_COUNT=2, base_addr=8'h10, memory preloaded mem[a]=a. start high for 2 cycles, then low; out_ready=1 throughout.
  - Response: 86 words 8'h10..8'h65, in order.
  - Response: out_kernel=0 for the first 43 words, 1 after.
  - Response: out_last_map high on words 8'h3A and 8'h65; out_last only on 8'h65.
  - Response: done pulses exactly once, 1 cycle after the last handshake, and busy falls with it.
- Backpressure: out_ready pseudo-random at 30% duty → no word lost or duplicated, and out_data and tags stay stable while out_valid=1 and out_ready=0.
- Address wrap: base_addr=8'hF0 → reads 8'hF0..8'hFF, then 8'h00..8'h45, and mem_addr wraps without a glitch.
- Reset mid-transfer: assert rst=0 for 1 cycle while presenting word 20 of kernel 0 → next cycle busy=0, out_valid=0 and done is never pulsed. A fresh start then restarts from the new base_addr, word 0, kernel 0.
- Start handling:
  - A start pulse while busy has no effect on addresses or counts.
  - start held high 10 cycles → mem_rd_en first asserts exactly 1 cycle after start falls.
- Reset behaviour: rst=0 held → all outputs 0, and start is ignored while rst=0.
